// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA memory arbiter.
package mem_arb_pkg;

    // Arbiter FSM: grants are only issued from IDLE; a granted read parks
    // the FSM in the matching response state for one cycle.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESP_CPU = 2'd1,
        RESP_DMA = 2'd2
    } arb_state_t;

    // Requester IDs, used as bit positions in the one-hot grant vector.
    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;

    // Width of the starvation counter.
    localparam int STARVE_W = 4;

    // Map an out-of-range starvation limit onto the largest legal value.
    function automatic logic [STARVE_W-1:0] clamp_limit(input int lim);
        if (lim < 1 || lim > 15) begin
            return 4'd15;
        end
        return lim[STARVE_W-1:0];
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive CPU grants taken while DMA was waiting.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter logic [STARVE_W-1:0] LIMIT = 4'd4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    // Clear wins over increment; the count never passes LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU, DMA) arbiter in front of a single synchronous-read memory.
// CPU has priority unless DMA has been passed over LIMIT times in a row.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [STARVE_W-1:0] LIMIT_EFF = clamp_limit(STARVE_LIMIT);

    arb_state_t state_q;
    arb_state_t state_d;
    logic [1:0] win;
    logic       at_limit;
    logic       starve_inc;
    logic       starve_clr;

    // Pick at most one winner, only in IDLE and never while reset is held.
    always_comb begin
        win = '0;
        if (!reset && state_q == IDLE) begin
            if (dma_req && at_limit) begin
                win[REQ_DMA] = 1'b1;
            end else if (cpu_req) begin
                win[REQ_CPU] = 1'b1;
            end else if (dma_req) begin
                win[REQ_DMA] = 1'b1;
            end
        end
    end

    // Steer the winner onto the memory bus; the bus idles at zero otherwise.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (win[REQ_CPU]) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (win[REQ_DMA]) begin
            mem_en    = 1'b1;
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_gnt = win[REQ_CPU];
    assign dma_gnt = win[REQ_DMA];

    // A reset landing on a response cycle drops that response.
    assign cpu_rvalid = !reset && (state_q == RESP_CPU);
    assign dma_rvalid = !reset && (state_q == RESP_DMA);
    assign rdata      = (cpu_rvalid || dma_rvalid) ? mem_rdata : '0;

    // Only a granted read leaves IDLE; response states last one cycle.
    always_comb begin
        state_d = IDLE;
        if (state_q == IDLE) begin
            if (win[REQ_CPU] && !cpu_we) begin
                state_d = RESP_CPU;
            end else if (win[REQ_DMA] && !dma_we) begin
                state_d = RESP_DMA;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Count CPU wins over a waiting DMA; forget once DMA is served or gone.
    assign starve_inc = win[REQ_CPU] && dma_req;
    assign starve_clr = win[REQ_DMA] || (state_q == IDLE && !dma_req);

    arb_starve_ctr #(
        .LIMIT(LIMIT_EFF)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (starve_inc),
        .clr_i     (starve_clr),
        .at_limit_o(at_limit)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous-read memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:1023];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_gnt   (dma_gnt),
        .dma_rvalid(dma_rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous-read memory, word addressed by addr[11:2].
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[11:2]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[64] = 32'hDEADBEEF;   // 0x100
        mem_rdata = '0;
        idle_inputs();

        // Reset held while both ports request: nothing may be granted.
        reset = 1; cpu_req = 1; dma_req = 1;
        @(negedge clk);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dma_gnt", dma_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
        tick();
        idle_inputs();
        tick();
        reset = 0;
        chk("rst_starve", dut.u_starve.cnt_q, 0);

        // CPU read of 0x100.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        @(negedge clk);
        chk("rd_cpu_gnt", cpu_gnt, 1);
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 32'h100);
        chk("rd_dma_gnt", dma_gnt, 0);
        tick();
        // Response cycle, with a one-cycle DMA request pulse.
        idle_inputs();
        dma_req = 1; dma_we = 0; dma_addr = 32'h200;
        @(negedge clk);
        chk("rd_cpu_rvalid", cpu_rvalid, 1);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        chk("rd_resp_mem_en", mem_en, 0);
        chk("rd_resp_cpu_gnt", cpu_gnt, 0);
        chk("pulse_dma_gnt", dma_gnt, 0);
        tick();
        chk("pulse_starve", dut.u_starve.cnt_q, 0);
        idle_inputs();
        @(negedge clk);
        chk("pulse_no_access", mem_en, 0);
        chk("pulse_dma_gnt2", dma_gnt, 0);
        tick();

        // Back-to-back DMA writes.
        dma_req = 1; dma_we = 1; dma_addr = 32'h200; dma_wdata = 32'h11111111;
        @(negedge clk);
        chk("dw0_gnt", dma_gnt, 1);
        chk("dw0_mem_we", mem_we, 1);
        chk("dw0_addr", mem_addr, 32'h200);
        chk("dw0_wdata", mem_wdata, 32'h11111111);
        tick();
        dma_addr = 32'h204; dma_wdata = 32'h22222222;
        @(negedge clk);
        chk("dw1_gnt", dma_gnt, 1);
        chk("dw1_mem_we", mem_we, 1);
        chk("dw1_addr", mem_addr, 32'h204);
        chk("dw1_rvalid", dma_rvalid, 0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("dw_after_rvalid", dma_rvalid, 0);
        tick();

        // Simultaneous reads: CPU first, DMA two cycles later.
        cpu_req = 1; cpu_addr = 32'h100;
        dma_req = 1; dma_addr = 32'h200;
        @(negedge clk);
        chk("sim_c1_cpu_gnt", cpu_gnt, 1);
        chk("sim_c1_dma_gnt", dma_gnt, 0);
        tick();
        chk("sim_starve1", dut.u_starve.cnt_q, 1);
        cpu_req = 0; cpu_addr = '0;
        @(negedge clk);
        chk("sim_c2_cpu_rvalid", cpu_rvalid, 1);
        chk("sim_c2_rdata", rdata, 32'hDEADBEEF);
        chk("sim_c2_dma", {dma_gnt, dma_rvalid}, 0);
        tick();
        @(negedge clk);
        chk("sim_c3_dma_gnt", dma_gnt, 1);
        chk("sim_c3_addr", mem_addr, 32'h200);
        chk("sim_c3_cpu_rvalid", cpu_rvalid, 0);
        tick();
        chk("sim_starve_clr", dut.u_starve.cnt_q, 0);
        dma_req = 0; dma_addr = '0;
        @(negedge clk);
        chk("sim_c4_dma_rvalid", dma_rvalid, 1);
        chk("sim_c4_cpu_rvalid", cpu_rvalid, 0);
        chk("sim_c4_rdata", rdata, 32'h11111111);
        tick();

        // Starvation: CPU writes continuously, DMA read of 0x204 waiting.
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h300;
        dma_req = 1; dma_we = 0; dma_addr = 32'h204;
        for (int k = 1; k <= 4; k++) begin
            cpu_wdata = 32'hC000_0000 + k;
            @(negedge clk);
            chk($sformatf("stv_cpu_gnt%0d", k), cpu_gnt, 1);
            chk($sformatf("stv_dma_gnt%0d", k), dma_gnt, 0);
            tick();
            chk($sformatf("stv_cnt%0d", k), dut.u_starve.cnt_q, k);
        end
        @(negedge clk);
        chk("stv5_dma_gnt", dma_gnt, 1);
        chk("stv5_cpu_gnt", cpu_gnt, 0);
        chk("stv5_addr", mem_addr, 32'h204);
        tick();
        chk("stv_cnt_after_dma", dut.u_starve.cnt_q, 0);
        dma_req = 0; dma_addr = '0;
        @(negedge clk);
        chk("stv_resp_rvalid", dma_rvalid, 1);
        chk("stv_resp_rdata", rdata, 32'h22222222);
        chk("stv_resp_cpu_gnt", cpu_gnt, 0);
        tick();
        @(negedge clk);
        chk("stv_cpu_resume", cpu_gnt, 1);
        tick();
        idle_inputs();

        // Reset during the CPU response cycle.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        @(negedge clk);
        chk("rr_cpu_gnt", cpu_gnt, 1);
        tick();
        idle_inputs();
        reset = 1;
        @(negedge clk);
        chk("rr_in_rst_rvalid", cpu_rvalid, 0);
        chk("rr_in_rst_rdata", rdata, 0);
        tick();
        reset = 0;
        @(negedge clk);
        chk("rr_next_rvalid", {cpu_rvalid, dma_rvalid}, 0);
        chk("rr_next_outs", {cpu_gnt, dma_gnt, mem_en, mem_we}, 0);
        chk("rr_next_bus", {mem_addr, mem_wdata}, 0);
        chk("rr_state", dut.state_q, 0);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width in bits.
REQ-002 Parameter DATA_W, default 32, memory data width in bits.
REQ-003 Parameter STARVE_LIMIT, default 4, maximum consecutive CPU grants while DMA waits; legal range 1-15.
REQ-004 clk  in  1  the only clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_req, cpu_we  in  1 each  CPU access request, write enable (1 = write).
REQ-007 cpu_addr, cpu_wdata  in  ADDR_W, DATA_W  CPU address, write data.
REQ-008 cpu_gnt, cpu_rvalid  out  1 each  CPU accept pulse, CPU read-data-valid pulse.
REQ-009 dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid: DMA port, same widths and meanings as the CPU port.
REQ-010 rdata  out  DATA_W  read data, shared by both ports, qualified by cpu_rvalid or dma_rvalid.
REQ-011 mem_en, mem_we  out  1 each  memory access strobe, memory write enable.
REQ-012 mem_addr, mem_wdata  out  ADDR_W, DATA_W  memory address, memory write data.
REQ-013 mem_rdata  in  DATA_W  synchronous-read data, valid the cycle after an mem_en=1, mem_we=0 access.

Function
REQ-014 FSM states: IDLE, RESP_CPU, RESP_DMA; arbitration occurs only in IDLE.
REQ-015 In IDLE, with at least one request, SHALL grant exactly one requester that same cycle: combinational mem_en=1, mem_* from the winner, winner's gnt=1 for one cycle.
REQ-016 Priority: CPU wins unless dma_req=1 and starve_cnt==STARVE_LIMIT, then DMA wins.
REQ-017 starve_cnt (4 bits): +1 on each CPU grant while dma_req=1; cleared on DMA grant or any IDLE cycle with dma_req=0; saturates at STARVE_LIMIT.
REQ-018 Granted write: mem_we=1, single cycle, no rvalid; FSM stays IDLE so a new grant is possible next cycle.
REQ-019 Granted read: mem_we=0; FSM -> RESP_CPU/RESP_DMA next cycle.
REQ-020 In RESP_x: rdata=mem_rdata, x_rvalid=1 for exactly one cycle, no grant, mem_en=0; next state IDLE. Read latency = 1 cycle grant-to-rvalid; read throughput 1 per 2 cycles.
REQ-021 Outside a grant cycle: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
REQ-022 Requesters hold req/we/addr/wdata stable until gnt; deasserting req before gnt SHALL cause no access and no counter change.
REQ-023 Simultaneous CPU and DMA requests in IDLE: exactly one gnt; the loser stays pending; no access is ever issued twice or dropped.
REQ-024 gnt and rvalid SHALL never be asserted on both ports in the same cycle.
REQ-025 An out-of-range STARVE_LIMIT SHALL be clamped to 15.

Reset
REQ-026 On reset: state=IDLE, starve_cnt=0, all gnt/rvalid/mem_en/mem_we=0, rdata=0, mem_addr/mem_wdata=0.
REQ-027 Reset asserted during RESP_x: the pending read response SHALL be dropped; no rvalid in the following cycle.
REQ-028 Reset asserted in the same cycle as a request: no gnt and no mem_en that cycle.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the state enum typedef (arb_state_t) and requester ID constants (REQ_CPU=0, REQ_DMA=1).
REQ-030 One sub-module, arb_starve_ctr, SHALL hold the saturating starvation counter and its limit compare; all other logic is in mem_arbiter.

Verification
REQ-031 CPU read only: cpu_req=1, we=0, addr=0x100, memory word 0xDEADBEEF -> cpu_gnt in cycle N, cpu_rvalid with rdata=0xDEADBEEF in N+1, mem_en=0 in N+1.
REQ-032 Back-to-back DMA writes to 0x200, 0x204 -> dma_gnt in consecutive cycles, mem_we=1 both cycles, no dma_rvalid.
REQ-033 Simultaneous reads from both ports -> cpu_gnt first, dma_gnt in IDLE two cycles later; rvalids never overlap.
REQ-034 CPU writes continuously, dma_req held, STARVE_LIMIT=4 -> 4 cpu_gnt, then dma_gnt on the 5th grant, then CPU resumes; starve_cnt=0 after the DMA grant.
REQ-035 Reset asserted in RESP_CPU -> no cpu_rvalid next cycle; all outputs 0; state IDLE.
REQ-036 dma_req pulsed for one cycle while CPU is granted -> no DMA access, starve_cnt unchanged.
